// File: rtl/vga_scan_if.sv
// Pixel interface between the VGA scan driver (master) and the Snake game logic (slave).
// The driver publishes scan coordinates; the game returns the pixel class and apple cell.
interface vga_scan_if;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic [1:0]  snake;
  logic [5:0]  apple_x;
  logic [5:0]  apple_y;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic        frame_tick;

  modport master (
    output x_pos, y_pos, hsync, vsync, rgb, frame_tick,
    input  snake, apple_x, apple_y
  );

  modport slave (
    input  x_pos, y_pos, hsync, vsync, rgb, frame_tick,
    output snake, apple_x, apple_y
  );
endinterface

// File: rtl/vga_scan_driver.sv
// VGA timing generator and pixel colouriser for the Snake display.
// Sync and RGB share one output register stage, so all lag the scan coordinates by one pixel.
module vga_scan_driver #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VIS   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33,
  parameter logic [11:0] C_WALL  = 12'hFFF,
  parameter logic [11:0] C_HEAD  = 12'hF80,
  parameter logic [11:0] C_BODY  = 12'h0F0,
  parameter logic [11:0] C_APPLE = 12'hF00
) (
  input logic        clk,
  input logic        rst,
  vga_scan_if.master vga
);

  localparam int unsigned CNT_W    = 12;
  localparam int unsigned RGB_W    = 12;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_VIS + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VIS + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic [1:0] CLS_HEAD = 2'd1;
  localparam logic [1:0] CLS_BODY = 2'd2;
  localparam logic [1:0] CLS_WALL = 2'd3;

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             hsync_q;
  logic             vsync_q;
  logic [RGB_W-1:0] rgb_q;
  logic             frame_tick_q;

  logic             pix_en_c;
  logic             h_wrap_c;
  logic             v_wrap_c;
  logic             hs_n_c;
  logic             vs_n_c;
  logic             vid_on_c;
  logic             apple_hit_c;
  logic             vblank_start_c;
  logic [RGB_W-1:0] colour_c;

  assign pix_en_c       = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign h_wrap_c       = (h_cnt == CNT_W'(H_TOTAL - 1));
  assign v_wrap_c       = (v_cnt == CNT_W'(V_TOTAL - 1));
  assign hs_n_c         = !((h_cnt >= CNT_W'(HS_START)) && (h_cnt < CNT_W'(HS_END)));
  assign vs_n_c         = !((v_cnt >= CNT_W'(VS_START)) && (v_cnt < CNT_W'(VS_END)));
  assign vid_on_c       = (h_cnt < CNT_W'(H_VIS)) && (v_cnt < CNT_W'(V_VIS));
  assign apple_hit_c    = vid_on_c && (h_cnt[9:4] == vga.apple_x) && (v_cnt[9:4] == vga.apple_y);
  assign vblank_start_c = pix_en_c && h_wrap_c && (v_cnt == CNT_W'(V_VIS - 1));

  // Pixel-clock divider
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (pix_en_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Horizontal and vertical scan counters
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en_c) begin
      if (h_wrap_c) begin
        h_cnt <= '0;
        v_cnt <= v_wrap_c ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  // Colour priority: wall, head, body, apple, then background
  always_comb begin
    colour_c = '0;
    if (vid_on_c) begin
      if (vga.snake == CLS_WALL) begin
        colour_c = C_WALL;
      end else if (vga.snake == CLS_HEAD) begin
        colour_c = C_HEAD;
      end else if (vga.snake == CLS_BODY) begin
        colour_c = C_BODY;
      end else if (apple_hit_c) begin
        colour_c = C_APPLE;
      end
    end
  end

  // Single output stage keeps sync and colour aligned to each other
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= '0;
    end else if (pix_en_c) begin
      hsync_q <= hs_n_c;
      vsync_q <= vs_n_c;
      rgb_q   <= colour_c;
    end
  end

  // High for the one clk after the edge that enters vertical blanking
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= vblank_start_c;
    end
  end

  assign vga.x_pos      = h_cnt;
  assign vga.y_pos      = v_cnt;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.rgb        = rgb_q;
  assign vga.frame_tick = frame_tick_q;

endmodule
